cordic_phase_gen: RTL and testbench
===================================

Name: cordic_phase_gen

Overview:
- Phase-stepping source that sits directly upstream of the pipelined CORDIC sin/cos core.
- Keeps a 0..359 degree accumulator and advances it by a programmable step once per programmable sample period.
- Emits the core's phase word: quadrant in bits [17:16], integer degrees 0..89 within the quadrant in bits [15:0].
- Delays its valid strobe by the core's fixed latency so downstream logic knows which cycles carry a fresh Sin/Cos.

Parameters:
- DIV_W, 16, width of the sample-period divider.
- LATENCY, 18, clocks from a Phase update to the matching Sin/Cos update at the core output.

Ports:
- CLK_50M  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- En  in  1  run request, level-sensitive.
- Step  in  9  degrees added per sample; values above 359 are treated as 359.
- Div  in  DIV_W  sample period minus 1, in clocks; 0 gives one sample per clock.
- Load  in  1  one-clock request to set the accumulator to Phase0.
- Phase0  in  9  load value in degrees; values above 359 are treated as 359.
- Phase  out  32  {14'd0, quadrant[1:0], residue[15:0]}; drives the CORDIC Phase input.
- Phase_Valid  out  1  one-clock pulse when Phase takes a new value.
- Sample_Valid  out  1  Phase_Valid delayed exactly LATENCY clocks; aligned with the core's Sin/Cos/Error.
- Wrap  out  1  one-clock pulse, coincident with the Phase_Valid of the sample whose successor wraps past 360.
- Busy  out  1  high in RUN and FLUSH.

Behaviour:
- Reset (asynchronous, any state, including mid-run):
  - State = IDLE; accumulator Acc = 0; divider count = 0.
  - Phase = 0, Phase_Valid = 0, Sample_Valid = 0, Wrap = 0, Busy = 0.
  - Delay line cleared.
- States:
  - IDLE: En=1 at an edge -> RUN, with divider count set to 0.
  - RUN: En=0 at an edge -> FLUSH, with the drain counter set to LATENCY.
  - FLUSH: counts down to 0, then -> IDLE. En is ignored in FLUSH; restart goes through IDLE, costing one clock.
- Tick:
  - Occurs in RUN when the count is 0; the count then reloads with the current Div. Otherwise the count decrements by 1.
  - Div changes take effect at the next reload.
  - The first tick occurs in the first RUN cycle, so Phase_Valid rises 2 edges after En is sampled high.
- On each tick, at the same edge:
  - Phase gets the quadrant/residue of the current Acc: q = 0 if Acc<90, 1 if <180, 2 if <270, else 3; residue = Acc - 90*q. Compare/subtract only, no divider.
  - Phase_Valid = 1.
  - Acc = Acc + Step_c; if the sum is >= 360, subtract 360 and Wrap = 1.
- Between ticks: Phase holds its value; Phase_Valid = 0; Wrap = 0.
- Load:
  - In IDLE or FLUSH: Acc = Phase0_c at that edge.
  - In RUN without a tick: Acc = Phase0_c.
  - In RUN coinciding with a tick: Load wins. Phase is formed from Phase0_c, and Acc = Phase0_c + Step_c, mod 360.
- Acc is retained across En stop/start, so phase stays continuous unless Load is used.
- Sample_Valid: a LATENCY-deep shift register of Phase_Valid. It keeps shifting in all states, so FLUSH drains every outstanding sample.
- Widths: Acc and the sum are 10 bits unsigned; residue is zero-extended to 16 bits; Phase[31:18] = 0.

Test Plan:
- Step=30, Div=0, Phase0=0, Load then En=1 -> Phase sequence 0x00000000, 0x0000001E, 0x0000003C, 0x00010000 … 0x0003003C, then 0x00000000 again; Wrap pulses with the 0x0003003C sample.
- Step=1, Div=4, Load Phase0=359, En=1 -> Phase_Valid every 5 clocks; Phase 0x00030059, then 0x00000000; Wrap on the first sample.
- Step=400 (clamp to 359), Phase0=0 -> Phase 0x00000000, 0x00030059, 0x00030058 (358), …; Wrap on each sample after the first.
- Any stream -> every Phase_Valid reproduced on Sample_Valid exactly 18 clocks later. After En=0, Busy stays high through FLUSH (LATENCY clocks, then 1 clock to IDLE); no Phase_Valid in FLUSH; all pending Sample_Valid pulses emerge.
- Load coinciding with a tick, Phase0=100, Step=10 -> Phase 0x0001000A; next sample 0x00010014.
- RST_N low mid-RUN with delay-line pulses pending -> all outputs 0 immediately, Busy=0, and no Sample_Valid after release.

Source files
------------

// File: rtl/cordic_phase_gen.sv
// Phase-stepping source for the pipelined CORDIC core: 0..359 degree accumulator, quadrant/residue phase word.
// Phase/Phase_Valid/Wrap are registered (1 edge after a tick); Sample_Valid trails Phase_Valid by LATENCY clocks.
// No backpressure: ticks are paced only by Div; dropping En drains the delay line in FLUSH before returning to IDLE.
module cordic_phase_gen #(
    parameter int DIV_W   = 16,
    parameter int LATENCY = 18
) (
    input  logic             CLK_50M,
    input  logic             RST_N,
    input  logic             En,
    input  logic [8:0]       Step,
    input  logic [DIV_W-1:0] Div,
    input  logic             Load,
    input  logic [8:0]       Phase0,
    output logic [31:0]      Phase,
    output logic             Phase_Valid,
    output logic             Sample_Valid,
    output logic             Wrap,
    output logic             Busy
);
    localparam int DW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t             state_q, state_d;
    logic [9:0]         acc_q, acc_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]      drain_q, drain_d;
    logic [31:0]        phase_q, phase_d;
    logic               pv_q, pv_d;
    logic               wrap_q, wrap_d;
    logic [LATENCY-1:0] sr_q;

    logic [9:0]  step_c, ph0_c, base, sum, res10;
    logic [1:0]  quad;
    logic        tick;

    assign step_c = (Step > 9'd359) ? 10'd359 : {1'b0, Step};
    assign ph0_c  = (Phase0 > 9'd359) ? 10'd359 : {1'b0, Phase0};

    // Ticks are suppressed on the edge that leaves RUN, so FLUSH never carries a Phase_Valid.
    assign tick = (state_q == RUN) && En && (cnt_q == '0);
    assign base = (tick && Load) ? ph0_c : acc_q;
    assign sum  = base + step_c;

    always_comb begin
        quad  = 2'd3;
        res10 = base - 10'd270;
        if (base < 10'd90) begin
            quad  = 2'd0;
            res10 = base;
        end else if (base < 10'd180) begin
            quad  = 2'd1;
            res10 = base - 10'd90;
        end else if (base < 10'd270) begin
            quad  = 2'd2;
            res10 = base - 10'd180;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        phase_d = phase_q;
        pv_d    = 1'b0;
        wrap_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Load) acc_d = ph0_c;
                if (En) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (!En) begin
                    state_d = FLUSH;
                    drain_d = DW'(LATENCY);
                    if (Load) acc_d = ph0_c;
                end else if (tick) begin
                    cnt_d   = Div;
                    phase_d = {14'd0, quad, 6'd0, res10};
                    pv_d    = 1'b1;
                    if (sum >= 10'd360) begin
                        acc_d  = sum - 10'd360;
                        wrap_d = 1'b1;
                    end else begin
                        acc_d = sum;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                    if (Load) acc_d = ph0_c;
                end
            end
            FLUSH: begin
                if (Load) acc_d = ph0_c;
                if (drain_q == '0) state_d = IDLE;
                else               drain_d = drain_q - DW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            drain_q <= '0;
            phase_q <= '0;
            pv_q    <= 1'b0;
            wrap_q  <= 1'b0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            phase_q <= phase_d;
            pv_q    <= pv_d;
            wrap_q  <= wrap_d;
            sr_q    <= {sr_q[LATENCY-2:0], pv_q};
        end
    end

    assign Phase        = phase_q;
    assign Phase_Valid  = pv_q;
    assign Wrap         = wrap_q;
    assign Sample_Valid = sr_q[LATENCY-1];
    assign Busy         = (state_q != IDLE);

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Self-checking bench for cordic_phase_gen: scoreboard of expected Phase/Wrap per sample plus a Sample_Valid delay reference.
module tb_cordic_phase_gen;
    localparam int LAT = 18;

    logic        CLK_50M = 1'b0;
    logic        RST_N   = 1'b0;
    logic        En      = 1'b0;
    logic [8:0]  Step    = '0;
    logic [15:0] Div     = '0;
    logic        Load    = 1'b0;
    logic [8:0]  Phase0  = '0;
    logic [31:0] Phase;
    logic        Phase_Valid, Sample_Valid, Wrap, Busy;

    cordic_phase_gen #(.DIV_W(16), .LATENCY(LAT)) dut (
        .CLK_50M(CLK_50M), .RST_N(RST_N), .En(En), .Step(Step), .Div(Div),
        .Load(Load), .Phase0(Phase0), .Phase(Phase), .Phase_Valid(Phase_Valid),
        .Sample_Valid(Sample_Valid), .Wrap(Wrap), .Busy(Busy)
    );

    always #10 CLK_50M = ~CLK_50M;

    typedef struct {
        logic [31:0] ph;
        logic        wr;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   m_acc = 0;
    int   m_step = 0;

    // Reference delay line for Sample_Valid, sampled with pre-edge values.
    logic [31:0] hist = '0;
    int pv_cnt = 0, sv_cnt = 0, sv_bad = 0;
    always @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            hist <= '0;
        end else begin
            if (Phase_Valid === 1'b1) pv_cnt <= pv_cnt + 1;
            if (Sample_Valid === 1'b1) sv_cnt <= sv_cnt + 1;
            if (Sample_Valid !== hist[LAT-1]) sv_bad <= sv_bad + 1;
            hist <= {hist[30:0], Phase_Valid};
        end
    end

    function automatic logic [31:0] ph(input int d);
        if (d < 90)       return 32'(d);
        else if (d < 180) return 32'h0001_0000 + 32'(d - 90);
        else if (d < 270) return 32'h0002_0000 + 32'(d - 180);
        else              return 32'h0003_0000 + 32'(d - 270);
    endfunction

    task automatic cyc();
        @(posedge CLK_50M);
        #1;
    endtask

    task automatic push_n(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.ph = ph(m_acc);
            e.wr = (m_acc + m_step >= 360);
            m_acc = (m_acc + m_step) % 360;
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int c = 0; c < 60; c++) begin
            cyc();
            if (Busy === 1'b0) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic load_idle(input int p0, input int st, input int dv);
        Step = 9'(st); Div = 16'(dv); Phase0 = 9'(p0); Load = 1'b1;
        cyc();
        Load = 1'b0;
        m_step = (st > 359) ? 359 : st;
        m_acc  = (p0 > 359) ? 359 : p0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (2) cyc();
        n_chk++; if (Phase === 32'd0) n_pass++; else $display("FAIL reset_phase: got %h want 0", Phase);
        n_chk++; if (Phase_Valid === 1'b0) n_pass++; else $display("FAIL reset_pv: got %b want 0", Phase_Valid);
        n_chk++; if (Sample_Valid === 1'b0) n_pass++; else $display("FAIL reset_sv: got %b want 0", Sample_Valid);
        n_chk++; if (Wrap === 1'b0) n_pass++; else $display("FAIL reset_wrap: got %b want 0", Wrap);
        n_chk++; if (Busy === 1'b0) n_pass++; else $display("FAIL reset_busy: got %b want 0", Busy);
        RST_N = 1'b1;
        cyc();
    endtask

    task automatic test_step30();
        exp_t e;
        int got = 0;
        load_idle(0, 30, 0);
        push_n(13);
        En = 1'b1;
        cyc();
        n_chk++;
        if (Phase_Valid === 1'b0 && Busy === 1'b1) n_pass++;
        else $display("FAIL step30_first_edge: pv=%b busy=%b want pv=0 busy=1", Phase_Valid, Busy);
        for (int c = 0; c < 40 && got < 13; c++) begin
            cyc();
            if (Phase_Valid === 1'b1) begin
                e = sb.pop_front();
                got++;
                n_chk++;
                if (Phase === e.ph && Wrap === e.wr) n_pass++;
                else $display("FAIL step30[%0d]: Phase=%h Wrap=%b want %h %b", got, Phase, Wrap, e.ph, e.wr);
                if (got == 13) En = 1'b0;
            end
        end
        n_chk++; if (got == 13) n_pass++; else $display("FAIL step30_count: got %0d samples want 13", got);
    endtask

    task automatic test_flush(input int exp_sv);
        int busy_n = 0, pv_n = 0, wr_n = 0, sv_n = 0;
        for (int c = 0; c < 40; c++) begin
            cyc();
            if (Busy !== 1'b1) break;
            busy_n++;
            if (Phase_Valid === 1'b1) pv_n++;
            if (Wrap === 1'b1) wr_n++;
            if (Sample_Valid === 1'b1) sv_n++;
        end
        n_chk++; if (busy_n == LAT + 1) n_pass++; else $display("FAIL flush_busy: %0d cycles want %0d", busy_n, LAT + 1);
        n_chk++; if (pv_n == 0) n_pass++; else $display("FAIL flush_pv: %0d pulses want 0", pv_n);
        n_chk++; if (wr_n == 0) n_pass++; else $display("FAIL flush_wrap: %0d pulses want 0", wr_n);
        n_chk++; if (sv_n == exp_sv) n_pass++; else $display("FAIL flush_sv: %0d pulses want %0d", sv_n, exp_sv);
    endtask

    task automatic test_div();
        exp_t e;
        int got = 0;
        int t_pv[3];
        bit ok;
        load_idle(359, 1, 4);
        push_n(3);
        En = 1'b1;
        for (int c = 0; c < 40 && got < 3; c++) begin
            cyc();
            if (Phase_Valid === 1'b1) begin
                e = sb.pop_front();
                t_pv[got] = c;
                got++;
                n_chk++;
                if (Phase === e.ph && Wrap === e.wr) n_pass++;
                else $display("FAIL div[%0d]: Phase=%h Wrap=%b want %h %b", got, Phase, Wrap, e.ph, e.wr);
                if (got == 3) En = 1'b0;
            end
        end
        n_chk++; if (got == 3) n_pass++; else $display("FAIL div_count: got %0d samples want 3", got);
        if (got == 3) begin
            n_chk++; if (t_pv[1] - t_pv[0] == 5) n_pass++; else $display("FAIL div_gap0: %0d want 5", t_pv[1] - t_pv[0]);
            n_chk++; if (t_pv[2] - t_pv[1] == 5) n_pass++; else $display("FAIL div_gap1: %0d want 5", t_pv[2] - t_pv[1]);
        end
        wait_idle(ok);
        n_chk++; if (ok) n_pass++; else $display("FAIL div_idle: Busy=%b want 0", Busy);
    endtask

    task automatic test_clamp();
        exp_t e;
        int got = 0;
        bit ok;
        load_idle(0, 400, 0);
        push_n(4);
        En = 1'b1;
        for (int c = 0; c < 20 && got < 4; c++) begin
            cyc();
            if (Phase_Valid === 1'b1) begin
                e = sb.pop_front();
                got++;
                n_chk++;
                if (Phase === e.ph && Wrap === e.wr) n_pass++;
                else $display("FAIL clamp[%0d]: Phase=%h Wrap=%b want %h %b", got, Phase, Wrap, e.ph, e.wr);
                if (got == 4) En = 1'b0;
            end
        end
        n_chk++; if (got == 4) n_pass++; else $display("FAIL clamp_count: got %0d samples want 4", got);
        wait_idle(ok);
        n_chk++; if (ok) n_pass++; else $display("FAIL clamp_idle: Busy=%b want 0", Busy);
    endtask

    task automatic test_load_tick();
        exp_t e;
        int got = 0;
        bit ok;
        load_idle(0, 10, 0);
        push_n(1);
        En = 1'b1;
        for (int c = 0; c < 10 && got < 1; c++) begin
            cyc();
            if (Phase_Valid === 1'b1) begin
                e = sb.pop_front();
                got++;
                n_chk++;
                if (Phase === e.ph && Wrap === e.wr) n_pass++;
                else $display("FAIL load_tick_pre: Phase=%h Wrap=%b want %h %b", Phase, Wrap, e.ph, e.wr);
            end
        end
        // Next edge is a tick with Load high: Load must win.
        Phase0 = 9'd100;
        Load   = 1'b1;
        m_acc  = 100;
        push_n(2);
        got = 0;
        for (int c = 0; c < 10 && got < 2; c++) begin
            cyc();
            Load = 1'b0;
            if (Phase_Valid === 1'b1) begin
                e = sb.pop_front();
                got++;
                n_chk++;
                if (Phase === e.ph && Wrap === e.wr) n_pass++;
                else $display("FAIL load_tick[%0d]: Phase=%h Wrap=%b want %h %b", got, Phase, Wrap, e.ph, e.wr);
                if (got == 2) En = 1'b0;
            end
        end
        n_chk++; if (got == 2) n_pass++; else $display("FAIL load_tick_count: got %0d samples want 2", got);
        wait_idle(ok);
        n_chk++; if (ok) n_pass++; else $display("FAIL load_tick_idle: Busy=%b want 0", Busy);
    endtask

    task automatic test_latency();
        n_chk++; if (sv_bad == 0) n_pass++; else $display("FAIL latency_align: %0d misaligned cycles want 0", sv_bad);
        n_chk++; if (pv_cnt == 23) n_pass++; else $display("FAIL latency_pv_total: %0d want 23", pv_cnt);
        n_chk++; if (sv_cnt == pv_cnt) n_pass++; else $display("FAIL latency_sv_total: %0d want %0d", sv_cnt, pv_cnt);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int sv_n = 0;
        int got = 0;
        bit ok;
        Step = 9'd30; Div = '0;
        En = 1'b1;
        repeat (6) cyc();
        #2;
        RST_N = 1'b0;
        #1;
        n_chk++; if (Phase === 32'd0) n_pass++; else $display("FAIL rstmid_phase: got %h want 0", Phase);
        n_chk++; if (Phase_Valid === 1'b0) n_pass++; else $display("FAIL rstmid_pv: got %b want 0", Phase_Valid);
        n_chk++; if (Wrap === 1'b0) n_pass++; else $display("FAIL rstmid_wrap: got %b want 0", Wrap);
        n_chk++; if (Busy === 1'b0) n_pass++; else $display("FAIL rstmid_busy: got %b want 0", Busy);
        n_chk++; if (Sample_Valid === 1'b0) n_pass++; else $display("FAIL rstmid_sv: got %b want 0", Sample_Valid);
        En = 1'b0;
        repeat (2) cyc();
        RST_N = 1'b1;
        for (int c = 0; c < 30; c++) begin
            cyc();
            if (Sample_Valid === 1'b1) sv_n++;
        end
        n_chk++; if (sv_n == 0) n_pass++; else $display("FAIL rstmid_sv_after: %0d pulses want 0", sv_n);
        // Accumulator must restart from 0 after reset.
        m_acc = 0; m_step = 30;
        push_n(1);
        En = 1'b1;
        for (int c = 0; c < 10 && got < 1; c++) begin
            cyc();
            if (Phase_Valid === 1'b1) begin
                e = sb.pop_front();
                got++;
                En = 1'b0;
                n_chk++;
                if (Phase === e.ph && Wrap === e.wr) n_pass++;
                else $display("FAIL rstmid_acc: Phase=%h Wrap=%b want %h %b", Phase, Wrap, e.ph, e.wr);
            end
        end
        n_chk++; if (got == 1) n_pass++; else $display("FAIL rstmid_count: got %0d samples want 1", got);
        En = 1'b0;
        wait_idle(ok);
        n_chk++; if (ok) n_pass++; else $display("FAIL rstmid_idle: Busy=%b want 0", Busy);
    endtask

    initial begin
        test_reset();
        test_step30();
        test_flush(13);
        test_div();
        test_clamp();
        test_load_tick();
        test_latency();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
